// File: rtl/haar_database_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : haar_database_reader_if
// Description : Request/ROM/stream bundle of the Haar classifier database
//               reader. master = reader side, slave = stage classifier and
//               ROM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface haar_database_reader_if #(
  parameter int DATA_WIDTH_12 = 12,
  parameter int ADDR_WIDTH    = 12
);
  logic                     i_database_request;
  logic                     i_restart;
  logic [ADDR_WIDTH-1:0]    o_mem_addr;
  logic [DATA_WIDTH_12-1:0] i_mem_data;
  logic                     o_data_valid;
  logic [DATA_WIDTH_12-1:0] o_data;
  logic [DATA_WIDTH_12-1:0] o_index_database;
  logic [DATA_WIDTH_12-1:0] o_index_classifier;
  logic [DATA_WIDTH_12-1:0] o_index_tree;
  logic                     o_end_single_classifier;
  logic                     o_end_tree;
  logic                     o_end_all_classifier;
  logic                     o_end_database;
  logic                     o_threshold_valid;

  modport master (
    input  i_database_request, i_restart, i_mem_data,
    output o_mem_addr, o_data_valid, o_data,
           o_index_database, o_index_classifier, o_index_tree,
           o_end_single_classifier, o_end_tree, o_end_all_classifier,
           o_end_database, o_threshold_valid
  );

  modport slave (
    output i_database_request, i_restart, i_mem_data,
    input  o_mem_addr, o_data_valid, o_data,
           o_index_database, o_index_classifier, o_index_tree,
           o_end_single_classifier, o_end_tree, o_end_all_classifier,
           o_end_database, o_threshold_valid
  );
endinterface
`default_nettype wire

// File: rtl/haar_database_reader.sv
`default_nettype none
// ============================================================================
// Module      : haar_database_reader
// Description : Streams the Haar classifier database out of a synchronous ROM
//               (1-cycle latency), tree-major / classifier / parameter order,
//               tagging each word with its indices and end-of-group flags.
//               Optional macro HAAR_DB_THRESHOLD_EN appends one stage
//               threshold word after the last parameter.
// Revision    : 1.0 - initial release
// ============================================================================
module haar_database_reader #(
  parameter int DATA_WIDTH_12            = 12,
  parameter int NUM_TREE                 = 3,
  parameter int NUM_CLASSIFIER           = 2,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int ADDR_WIDTH               = 12
) (
  input wire clk_fpga,
  input wire reset_fpga,
  haar_database_reader_if.master bus
);

  localparam logic [DATA_WIDTH_12-1:0] LAST_PARAM = DATA_WIDTH_12'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [DATA_WIDTH_12-1:0] LAST_CLS   = DATA_WIDTH_12'(NUM_CLASSIFIER - 1);
  localparam logic [DATA_WIDTH_12-1:0] LAST_TREE  = DATA_WIDTH_12'(NUM_TREE - 1);
  localparam logic [DATA_WIDTH_12-1:0] ONE_D      = DATA_WIDTH_12'(1);
  localparam logic [ADDR_WIDTH-1:0]    ONE_A      = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_THRESH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH_12-1:0] param_q, param_d;
  logic [DATA_WIDTH_12-1:0] cls_q, cls_d;
  logic [DATA_WIDTH_12-1:0] tree_q, tree_d;
  // Linear address tracks the counters; it also naturally lands on the
  // threshold word right after the last parameter.
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;

  // Tags of the word currently in flight through the ROM.
  logic                     valid_q, valid_d;
  logic [DATA_WIDTH_12-1:0] idx_param_q, idx_param_d;
  logic [DATA_WIDTH_12-1:0] idx_cls_q, idx_cls_d;
  logic [DATA_WIDTH_12-1:0] idx_tree_q, idx_tree_d;
  logic                     end_sc_q, end_sc_d;
  logic                     end_tree_q, end_tree_d;
  logic                     end_all_q, end_all_d;
  logic                     end_db_q, end_db_d;
  logic                     thr_q, thr_d;

  logic w_issue, w_thresh, w_lp, w_lc, w_lt, w_last;

  // Next-state, counter and pipeline-tag logic.
  always_comb begin
    state_d     = state_q;
    param_d     = param_q;
    cls_d       = cls_q;
    tree_d      = tree_q;
    addr_d      = addr_q;

    w_issue  = (state_q != S_DONE) && bus.i_database_request && !bus.i_restart;
    w_thresh = (state_q == S_THRESH);
    w_lp     = (param_q == LAST_PARAM);
    w_lc     = (cls_q == LAST_CLS);
    w_lt     = (tree_q == LAST_TREE);
    w_last   = !w_thresh && w_lp && w_lc && w_lt;

    valid_d     = w_issue;
    idx_param_d = (w_issue && !w_thresh) ? param_q : '0;
    idx_cls_d   = (w_issue && !w_thresh) ? cls_q   : '0;
    idx_tree_d  = (w_issue && !w_thresh) ? tree_q  : '0;
    end_sc_d    = w_issue && !w_thresh && w_lp;
    end_tree_d  = w_issue && !w_thresh && w_lp && w_lc;
    end_all_d   = w_issue && w_last;
`ifdef HAAR_DB_THRESHOLD_EN
    end_db_d    = w_issue && w_thresh;
    thr_d       = w_issue && w_thresh;
`else
    end_db_d    = w_issue && w_last;
    thr_d       = 1'b0;
`endif

    if (bus.i_restart) begin
      state_d = S_IDLE;
      param_d = '0;
      cls_d   = '0;
      tree_d  = '0;
      addr_d  = '0;
    end else if (w_issue) begin
      addr_d = addr_q + ONE_A;
      if (w_thresh) begin
        state_d = S_DONE;
      end else if (w_last) begin
        param_d = '0;
        cls_d   = '0;
        tree_d  = '0;
`ifdef HAAR_DB_THRESHOLD_EN
        state_d = S_THRESH;
`else
        state_d = S_DONE;
`endif
      end else begin
        state_d = S_STREAM;
        if (w_lp) begin
          param_d = '0;
          if (w_lc) begin
            cls_d  = '0;
            tree_d = tree_q + ONE_D;
          end else begin
            cls_d = cls_q + ONE_D;
          end
        end else begin
          param_d = param_q + ONE_D;
        end
      end
    end
  end

  // State, counters and in-flight tags; reset discards any in-flight word.
  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      state_q     <= S_IDLE;
      param_q     <= '0;
      cls_q       <= '0;
      tree_q      <= '0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      idx_param_q <= '0;
      idx_cls_q   <= '0;
      idx_tree_q  <= '0;
      end_sc_q    <= 1'b0;
      end_tree_q  <= 1'b0;
      end_all_q   <= 1'b0;
      end_db_q    <= 1'b0;
      thr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      param_q     <= param_d;
      cls_q       <= cls_d;
      tree_q      <= tree_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      idx_param_q <= idx_param_d;
      idx_cls_q   <= idx_cls_d;
      idx_tree_q  <= idx_tree_d;
      end_sc_q    <= end_sc_d;
      end_tree_q  <= end_tree_d;
      end_all_q   <= end_all_d;
      end_db_q    <= end_db_d;
      thr_q       <= thr_d;
    end
  end

  assign bus.o_mem_addr              = addr_q;
  assign bus.o_data_valid            = valid_q;
  assign bus.o_data                  = valid_q ? bus.i_mem_data : '0;
  assign bus.o_index_database        = idx_param_q;
  assign bus.o_index_classifier      = idx_cls_q;
  assign bus.o_index_tree            = idx_tree_q;
  assign bus.o_end_single_classifier = end_sc_q;
  assign bus.o_end_tree              = end_tree_q;
  assign bus.o_end_all_classifier    = end_all_q;
  assign bus.o_end_database          = end_db_q;
  assign bus.o_threshold_valid       = thr_q;

endmodule
`default_nettype wire

// File: tb/tb_haar_database_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_haar_database_reader
// Description : Directed self-checking bench for haar_database_reader with a
//               ROM model word[a] = a + 100. Follows HAAR_DB_THRESHOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_haar_database_reader;

`ifdef HAAR_DB_THRESHOLD_EN
  localparam int N_WORDS = 109;
`else
  localparam int N_WORDS = 108;
`endif

  typedef struct packed {
    logic [11:0] data;
    logic [40:0] meta;  // idx_db, idx_cls, idx_tree, esc, etree, eall, edb, thr
  } rec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  rec_t q[$];

  haar_database_reader_if #(.DATA_WIDTH_12(12), .ADDR_WIDTH(12)) bus ();

  haar_database_reader dut (
    .clk_fpga   (clk),
    .reset_fpga (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model, one cycle of read latency.
  always @(posedge clk) bus.i_mem_data <= 12'(bus.o_mem_addr + 12'd100);

  // Capture every valid word away from the active edge.
  always @(negedge clk) begin
    if (bus.o_data_valid)
      q.push_back({bus.o_data, bus.o_index_database, bus.o_index_classifier,
                   bus.o_index_tree, bus.o_end_single_classifier, bus.o_end_tree,
                   bus.o_end_all_classifier, bus.o_end_database, bus.o_threshold_valid});
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [40:0] exp_meta(input int i);
    int  p, c, t;
    logic esc, etr, eal, edb, thr;
    if (i >= 108) return {36'd0, 5'b00011};  // threshold word
    p   = i % 18;
    c   = (i / 18) % 2;
    t   = i / 36;
    esc = (p == 17);
    etr = esc && (c == 1);
    eal = etr && (t == 2);
`ifdef HAAR_DB_THRESHOLD_EN
    edb = 1'b0;
`else
    edb = eal;
`endif
    thr = 1'b0;
    return {12'(p), 12'(c), 12'(t), esc, etr, eal, edb, thr};
  endfunction

  task automatic do_restart();
    bus.i_restart = 1'b1;
    bus.i_database_request = 1'b0;
    cycles(1);
    bus.i_restart = 1'b0;
    cycles(1);
    q.delete();
  endtask

  initial begin
    int thr_cnt;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.i_database_request = 1'b0;
    bus.i_restart = 1'b0;
    cycles(3);

    // Reset state
    check("rst_addr",  64'(bus.o_mem_addr), 64'd0);
    check("rst_valid", 64'(bus.o_data_valid), 64'd0);
    check("rst_data",  64'(bus.o_data), 64'd0);
    check("rst_flags", 64'({bus.o_end_single_classifier, bus.o_end_tree, bus.o_end_all_classifier,
                            bus.o_end_database, bus.o_threshold_valid, bus.o_index_tree}), 64'd0);
    rst = 1'b0;
    cycles(1);
    q.delete();

    // Full stream, request held high for 110 cycles
    bus.i_database_request = 1'b1;
    cycles(110);
    bus.i_database_request = 1'b0;
    cycles(3);
    check("full_count", 64'(q.size()), 64'(N_WORDS));
    check("done_valid", 64'(bus.o_data_valid), 64'd0);
    thr_cnt = 0;
    foreach (q[i]) if (q[i].meta[0]) thr_cnt++;
`ifdef HAAR_DB_THRESHOLD_EN
    check("thr_count", 64'(thr_cnt), 64'd1);
`else
    check("thr_count", 64'(thr_cnt), 64'd0);
`endif
    for (int i = 0; i < N_WORDS && i < q.size(); i++) begin
      check($sformatf("full_data[%0d]", i), 64'(q[i].data), 64'(100 + i));
      check($sformatf("full_meta[%0d]", i), 64'(q[i].meta), 64'(exp_meta(i)));
    end
    if (q.size() > 36) begin
      check("w17_esc_cls_tree", 64'({q[17].meta[4], q[17].meta[28:17]}), {51'd0, 1'b1, 12'd0});
      check("w35_etree_tree",   64'({q[35].meta[3], q[35].meta[16:5]}), {51'd0, 1'b1, 12'd0});
      check("w36_tree_db",      64'({q[36].meta[16:5], q[36].meta[40:29]}), {40'd0, 12'd1, 12'd0});
    end

    // Restart from DONE and a request gap: data stays contiguous
    do_restart();
    bus.i_database_request = 1'b1;
    cycles(5);
    bus.i_database_request = 1'b0;
    cycles(5);
    bus.i_database_request = 1'b1;
    cycles(10);
    bus.i_database_request = 1'b0;
    cycles(2);
    check("gap_count", 64'(q.size()), 64'd15);
    for (int i = 0; i < 15 && i < q.size(); i++)
      check($sformatf("gap_data[%0d]", i), 64'(q[i].data), 64'(100 + i));

    // Restart together with request at word 40
    do_restart();
    bus.i_database_request = 1'b1;
    cycles(40);
    check("pre_rs_data", 64'(bus.o_data), 64'd139);
    bus.i_restart = 1'b1;
    cycles(1);
    check("rs_valid", 64'(bus.o_data_valid), 64'd0);
    check("rs_addr",  64'(bus.o_mem_addr), 64'd0);
    bus.i_restart = 1'b0;
    cycles(1);
    check("rs_first_valid", 64'(bus.o_data_valid), 64'd1);
    check("rs_first_data",  64'(bus.o_data), 64'd100);

    // Asynchronous reset mid-stream
    cycles(20);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.o_data_valid), 64'd0);
    check("arst_data",  64'(bus.o_data), 64'd0);
    check("arst_addr",  64'(bus.o_mem_addr), 64'd0);
    check("arst_idx",   64'({bus.o_index_database, bus.o_index_classifier, bus.o_index_tree}), 64'd0);
    cycles(1);
    #2;
    rst = 1'b0;
    q.delete();
    cycles(5);
    check("arst_count", 64'(q.size()), 64'd4);
    if (q.size() >= 2) begin
      check("arst_w0", 64'(q[0].data), 64'd100);
      check("arst_w1", 64'(q[1].data), 64'd101);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/haar_database_reader.md
HAAR_DATABASE_READER -- requirements
Module: haar_database_reader

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH_12 default 12, data/index width; NUM_TREE default 3, trees per stage; NUM_CLASSIFIER default 2, classifiers per tree; NUM_PARAM_PER_CLASSIFIER default 18, words per classifier; ADDR_WIDTH default 12, memory address width.
REQ-002 clk_fpga  in  1  sole clock, all state on rising edge.
REQ-003 reset_fpga  in  1  asynchronous, active-high reset.
REQ-004 i_database_request  in  1  level request from stage classifier; one word fetched per cycle while high.
REQ-005 i_restart  in  1  synchronous restart of stage stream from word 0.
REQ-006 o_mem_addr  out  ADDR_WIDTH  read address to synchronous ROM (1-cycle read latency).
REQ-007 i_mem_data  in  DATA_WIDTH_12  ROM read data, valid one cycle after o_mem_addr.
REQ-008 o_data_valid  out  1  o_data and all index/end outputs valid this cycle.
REQ-009 o_data  out  DATA_WIDTH_12  parameter word.
REQ-010 o_index_database / o_index_classifier / o_index_tree  out  DATA_WIDTH_12 each  param, classifier-in-tree, tree indices of o_data.
REQ-011 o_end_single_classifier / o_end_tree / o_end_all_classifier / o_end_database / o_threshold_valid  out  1 each  end-of-group flags, qualified by o_data_valid.

Function
REQ-012 Stream order SHALL be tree-major, then classifier, then param; linear address = (tree*NUM_CLASSIFIER + classifier)*NUM_PARAM_PER_CLASSIFIER + param.
REQ-013 States SHALL be IDLE, STREAM, THRESH, DONE; IDLE->STREAM on first issued read; STREAM->THRESH or DONE after final parameter read issued; THRESH->DONE after threshold read issued; DONE->IDLE only on i_restart.
REQ-014 A read SHALL be issued in a cycle iff state is IDLE/STREAM/THRESH, i_database_request=1 and i_restart=0; issue increments counters.
REQ-015 o_mem_addr SHALL be driven from registered counters (no combinational path from inputs).
REQ-016 o_data_valid SHALL be 1 exactly one cycle after each issued read; o_data = i_mem_data of that cycle; indices/flags are those of the issued address (pipelined alongside).
REQ-017 Deasserting i_database_request SHALL freeze counters; the in-flight word still emerges with o_data_valid=1 next cycle; no word is lost or repeated.
REQ-018 param counter SHALL wrap NUM_PARAM_PER_CLASSIFIER-1->0 incrementing classifier; classifier wraps NUM_CLASSIFIER-1->0 incrementing tree.
REQ-019 o_end_single_classifier SHALL flag param=NUM_PARAM_PER_CLASSIFIER-1; o_end_tree additionally requires classifier=NUM_CLASSIFIER-1; o_end_all_classifier additionally requires tree=NUM_TREE-1.
REQ-020 In DONE no reads SHALL issue and o_data_valid SHALL be 0 (after the final in-flight word).
REQ-021 i_restart SHALL clear counters, enter IDLE and squash any in-flight word (o_data_valid=0 next cycle); restart wins over simultaneous request.
REQ-022 All flags and o_data_valid SHALL be 0 whenever o_data_valid would be 0.

Reset
REQ-023 reset_fpga SHALL asynchronously force state IDLE, counters 0, o_mem_addr 0, o_data_valid 0, o_data 0, all indices 0, all flags 0.
REQ-024 Reset asserted mid-stream SHALL discard in-flight word; first post-reset issue is address 0.

Configuration
REQ-025 Macro HAAR_DB_THRESHOLD_EN: defined -> after final parameter one extra word at address NUM_TREE*NUM_CLASSIFIER*NUM_PARAM_PER_CLASSIFIER is read in THRESH, emerging with o_threshold_valid=1 and o_end_database=1, index outputs 0; not defined -> THRESH unreachable, o_threshold_valid tied 0, o_end_database=1 coincides with o_end_all_classifier.

Verification (defaults, ROM word[a]=a+100)
REQ-026 Request held high 110 cycles with macro -> 109 valid words, data 100..208, word 107 has end_all_classifier, word 108 has threshold_valid+end_database, then valid=0.
REQ-027 Same without macro -> 108 words, word 107 has end_all_classifier and end_database, o_threshold_valid never 1.
REQ-028 Request high cycles 0-4, low 5-9, high 10+ -> words 0..4 then 5.. contiguous, no gap/duplicate in data sequence.
REQ-029 Word 17 -> end_single_classifier=1, index_classifier=0, index_tree=0; word 35 -> end_tree=1, index_tree=0; word 36 -> index_tree=1, index_database=0.
REQ-030 i_restart with request at word 40 -> next cycle valid=0, following issue address 0, data 100.
REQ-031 reset_fpga pulsed asynchronously mid-stream (between edges) -> outputs 0 immediately, stream restarts at address 0.
